tanh_grad_backprop: RTL and testbench

//  Backward-pass partner of the PLAN tanh activation. Takes a stored forward output
//  y = tanh(x) and an upstream gradient g, and returns g_out = g * (1 - y^2) plus the

---
 rtl/tanh_grad_backprop.sv | 127 ++++++++++++
 tb/tb_tanh_grad_backprop.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/tanh_grad_backprop.sv
// Backward pass of tanh: deriv_out = 1 - y^2, grad_out = g * (1 - y^2).
// Both products use one bit-serial shift-add multiplier that runs twice per operation.
module tanh_grad_backprop #(
    parameter int unsigned N    = 32,
    parameter int unsigned FRAC = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] y_in,
    input  logic [N-1:0] grad_in,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] grad_out,
    output logic [N-1:0] deriv_out,
    output logic         out_valid,
    input  logic         out_ready
);

    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned W2 = 2 * N;
    localparam logic [N-1:0]  ONE  = {{(N-1){1'b0}}, 1'b1} << FRAC;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SQ,
        S_SUB,
        S_MUL,
        S_DONE
    } state_t;

    state_t         r_state;
    logic [CW-1:0]  r_cnt;
    logic [W2-1:0]  r_acc;
    logic [W2-1:0]  r_mcand;
    logic [N-1:0]   r_mplier;
    logic           r_gneg;
    logic [N-1:0]   r_gmag;
    logic           r_in_ready;
    logic           r_out_valid;
    logic [N-1:0]   r_grad;
    logic [N-1:0]   r_deriv;

    logic [N-1:0]   w_y_mag;
    logic [N-1:0]   w_a;
    logic [N-1:0]   w_g_mag;
    logic [N-1:0]   w_acc_shr;
    logic [N-1:0]   w_d;
    logic [W2-1:0]  w_acc_next;

    // Unsigned magnitudes; the most-negative y maps to 2^(N-1) and so clamps to ONE.
    assign w_y_mag    = y_in[N-1] ? -y_in : y_in;
    assign w_a        = (w_y_mag > ONE) ? ONE : w_y_mag;
    assign w_g_mag    = grad_in[N-1] ? -grad_in : grad_in;

    assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign w_acc_shr  = r_acc[FRAC +: N];
    assign w_d        = (w_acc_shr > ONE) ? '0 : (ONE - w_acc_shr);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_gneg      <= 1'b0;
            r_gmag      <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_grad      <= '0;
            r_deriv     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_in_ready <= 1'b0;
                        r_acc      <= '0;
                        r_mcand    <= {{N{1'b0}}, w_a};
                        r_mplier   <= w_a;
                        r_gneg     <= grad_in[N-1];
                        r_gmag     <= w_g_mag;
                        r_cnt      <= '0;
                        r_state    <= S_SQ;
                    end
                end
                // One multiplier bit per cycle, LSB first; shared by both passes.
                S_SQ, S_MUL: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CW'(1);
                    if (r_cnt == LAST) begin
                        r_state <= (r_state == S_SQ) ? S_SUB : S_DONE;
                    end
                end
                S_SUB: begin
                    r_deriv  <= w_d;
                    r_acc    <= '0;
                    r_mcand  <= {{N{1'b0}}, r_gmag};
                    r_mplier <= w_d;
                    r_cnt    <= '0;
                    r_state  <= S_MUL;
                end
                S_DONE: begin
                    if (!r_out_valid) begin
                        r_grad      <= r_gneg ? -w_acc_shr : w_acc_shr;
                        r_out_valid <= 1'b1;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign grad_out  = r_grad;
    assign deriv_out = r_deriv;

endmodule

// File: tb/tb_tanh_grad_backprop.sv
// Scoreboard bench for tanh_grad_backprop: the driver queues expected results,
// a separate monitor checks latency on out_valid rise and data on each handshake.
module tb_tanh_grad_backprop;

    localparam int unsigned N   = 32;
    localparam int          LAT = 66;
    localparam logic [31:0] ONE = 32'h0001_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] y_in, grad_in;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] grad_out, deriv_out;
    logic        out_valid;
    logic        out_ready;

    typedef struct {
        logic [31:0] d;
        logic [31:0] g;
        longint      acc;
    } exp_t;

    exp_t   q[$];
    longint cyc = 0;
    int     n_cmp = 0;
    int     n_err = 0;
    logic   prev_ov = 1'b0;

    tanh_grad_backprop #(.N(N), .FRAC(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .y_in      (y_in),
        .grad_in   (grad_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .grad_out  (grad_out),
        .deriv_out (deriv_out),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Reference: magnitude multiply, truncation toward zero at each >> 16.
    task automatic model(input logic [31:0] y, input logic [31:0] g,
                         output logic [31:0] d, output logic [31:0] go);
        longint a, sq, dd, gm, m;
        a  = y[31] ? (64'h1_0000_0000 - longint'(y)) : longint'(y);
        if (a > longint'(ONE)) a = longint'(ONE);
        sq = (a * a) >>> 16;
        dd = (sq > longint'(ONE)) ? 0 : longint'(ONE) - sq;
        gm = g[31] ? (64'h1_0000_0000 - longint'(g)) : longint'(g);
        m  = (gm * dd) >>> 16;
        d  = 32'(dd);
        go = g[31] ? 32'(-m) : 32'(m);
    endtask

    task automatic send(input logic [31:0] y, input logic [31:0] g,
                        input logic [31:0] ed, input logic [31:0] eg, input bit push);
        int   t = 0;
        exp_t e;
        @(negedge clk);
        while (!in_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: in_ready stayed low for %0d cycles", t);
            return;
        end
        y_in     = y;
        grad_in  = g;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        e.d   = ed;
        e.g   = eg;
        e.acc = cyc;
        if (push) q.push_back(e);
        in_valid = 1'b0;
    endtask

    // Monitor: latency on the rising edge of out_valid, data on each accepted result.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && !prev_ov) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_out: out_valid rose with nothing outstanding");
                end else if (int'(cyc - q[0].acc) != LAT) begin
                    n_err++;
                    $display("FAIL latency: got %0d expected %0d", int'(cyc - q[0].acc), LAT);
                end
            end
            if (out_valid && out_ready && q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                chk("deriv_out", deriv_out, e.d);
                chk("grad_out", grad_out, e.g);
            end
        end
        prev_ov = out_valid;
    end

    initial begin
        logic [31:0] ry, rg, rd, rgo;
        int t;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; y_in = '0; grad_in = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_grad", grad_out, 32'h0);
        chk("rst_deriv", deriv_out, 32'h0);

        // Directed vectors
        send(32'h0000_8000, 32'h0001_0000, 32'h0000_C000, 32'h0000_C000, 1);
        send(32'hFFFF_8000, 32'h0002_0000, 32'h0000_C000, 32'h0001_8000, 1);
        send(32'h0000_0000, 32'hFFFE_0000, 32'h0001_0000, 32'hFFFE_0000, 1);
        send(32'h0001_0000, 32'h0005_0000, 32'h0000_0000, 32'h0000_0000, 1);
        send(32'h0001_8000, 32'h0005_0000, 32'h0000_0000, 32'h0000_0000, 1);
        send(32'h8000_0000, 32'h0001_2345, 32'h0000_0000, 32'h0000_0000, 1);
        send(32'h0000_0000, 32'h8000_0000, 32'h0001_0000, 32'h8000_0000, 1);
        send(32'h0000_0001, 32'hFFFF_FFFF, 32'h0001_0000, 32'hFFFF_FFFF, 1);
        send(32'h0000_B505, 32'h0000_0003, 32'h0000_8000, 32'h0000_0001, 1);
        send(32'h0000_B505, 32'hFFFF_FFFD, 32'h0000_8000, 32'hFFFF_FFFF, 1);

        // Reset in the middle of the second multiply pass drops the op
        send(32'h0000_8000, 32'h0001_0000, 32'h0, 32'h0, 0);
        repeat (45) @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_grad", grad_out, 32'h0);
        chk("midrst_deriv", deriv_out, 32'h0);
        repeat (80) @(posedge clk);

        // Back-pressure: result held, busy input ignored
        out_ready = 1'b0;
        send(32'h0000_4000, 32'h0003_0000, 32'h0000_F000, 32'h0002_D000, 1);
        t = 0;
        while (!out_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!out_valid) begin
            n_cmp++;
            n_err++;
            $display("FAIL bp_timeout: out_valid never rose");
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_grad", grad_out, 32'h0002_D000);
            chk("bp_deriv", deriv_out, 32'h0000_F000);
            chk("bp_valid", {31'b0, out_valid}, 32'd1);
            chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
            in_valid = i[0];
            y_in     = 32'h0000_0000;
            grad_in  = 32'h7777_0000;
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_idle_in_ready", {31'b0, in_ready}, 32'd1);
        chk("bp_idle_out_valid", {31'b0, out_valid}, 32'd0);
        send(32'h0000_4000, 32'hFFFD_0000, 32'h0000_F000, 32'hFFFD_3000, 1);

        // Random |y| <= ONE against the reference model
        for (int i = 0; i < 100; i++) begin
            ry = 32'($urandom_range(0, 32'h0002_0000)) - ONE;
            rg = $urandom;
            model(ry, rg, rd, rgo);
            send(ry, rg, rd, rgo, 1);
        end

        t = 0;
        while (q.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: %0d results never returned", q.size());
        end
        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
